fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the program counter and requests instruction words from program memory over a req/ack handshake.
- Latches each fetched word into an instruction register and presents its opcode field to the control unit.
- Advances the PC by +1 or to the embedded jump target, as selected by the control unit's s_inc.

Parameters:
- AW, 10, program address width; jump target is instr[AW-1:0].
- IW, 16, instruction width; opcode is instr[IW-1:IW-6].
- CW, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- s_inc  input  1  from control unit: 1 = PC+1, 0 = load jump target.
- halt  input  1  request to stop fetching after the current instruction.
- imem_ack  input  1  program memory: imem_data is valid this cycle.
- imem_data  input  IW  program memory read data.
- imem_req  output  1  fetch request.
- imem_addr  output  AW  fetch address, always equal to pc.
- instr  output  IW  instruction register.
- opcode  output  6  instr[IW-1:IW-6], wired to the control unit.
- instr_valid  output  1  high for exactly the cycle in which s_inc is consumed.
- pc  output  AW  current program counter.
- halted  output  1  high in HALTED state.
- retired  output  CW  count of executed instructions.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, pc=0, instr=0 (noop), retired=0. All 1-bit outputs are 0.
- States IDLE, FETCH, EXEC, HALTED; outputs decoded from registered state only.
- IDLE: imem_req=0. The next edge moves to FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc.
  - On an edge with imem_ack=1: instr<=imem_data, go to EXEC.
  - Otherwise stay in FETCH, holding req and address stable.
  - The request is never withdrawn before ack, even if halt rises.
- Ack timing: ack in the same cycle req first rises is legal, giving a 1-cycle fetch. imem_ack is ignored outside FETCH.
- EXEC: instr_valid=1, imem_req=0. On the edge:
  - pc<=s_inc ? pc+1 : instr[AW-1:0].
  - retired<=retired+1.
  - Next state is HALTED if halt=1, else FETCH.
- Throughput with zero-wait memory: 2 cycles per instruction.
- HALTED: imem_req=0, halted=1, pc frozen. Returns to FETCH on the first edge with halt=0.
- Wrap-around:
  - pc+1 wraps modulo 2^AW (all-ones to 0).
  - retired saturates at all-ones and never wraps.
- s_inc is sampled only in EXEC. Its value in other states has no effect.
- A jump to its own address (target==pc) is legal and refetches the same word.
- Reset mid-fetch or mid-EXEC aborts immediately: no PC update, no counter increment. After release, the first request is to address 0.

Test Plan:
- Reset, then zero-wait memory (ack tied 1), mem[0..2]=16'h0000, s_inc=1 -> requests to addresses 0,1,2. instr_valid on cycles 3,5,7 after release. retired=3.
- mem[0]=16'h0405 (jump, target 5), s_inc=0 in EXEC -> next imem_addr=5. pc=5. Address 1 is never requested.
- Ack delayed 3 cycles at address 4 -> imem_req and imem_addr=4 held stable for 3 cycles. instr updates only on the ack edge, with one instr_valid pulse.
- pc preloaded to 10'h3FF via jump, s_inc=1 -> next fetch address 0.
- halt=1 raised during FETCH with pending ack -> fetch completes, one EXEC, then HALTED (halted=1, imem_req=0). Dropping halt resumes at pc+1.
- reset_n pulsed low while in EXEC -> pc=0, retired=0, instr=0, instr_valid=0 immediately without waiting for clk. Next request is to address 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Program-memory fetch handshake between fetch_unit and instruction memory.
// master: fetch side drives imem_req/imem_addr; slave: memory drives imem_ack/imem_data.
interface fetch_unit_if #(
   parameter int AW = 10,
   parameter int IW = 16
) ();
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [IW-1:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch, instruction register, retire count.
// Ports: clk, reset_n, s_inc, halt, imem (master), instr, opcode, instr_valid, pc, halted, retired.
module fetch_unit #(
   parameter int AW = 10,
   parameter int IW = 16,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          s_inc,
   input  logic          halt,
   fetch_unit_if.master  imem,
   output logic [IW-1:0] instr,
   output logic [5:0]    opcode,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          halted,
   output logic [CW-1:0] retired
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = FETCH;
         FETCH:   if (imem.imem_ack) state_nx = EXEC;
         EXEC:    state_nx = halt ? HALTED : FETCH;
         HALTED:  if (!halt) state_nx = FETCH;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      imem.imem_req = 1'b0;
      instr_valid   = 1'b0;
      halted        = 1'b0;
      unique case (state)
         IDLE:    ;
         FETCH:   imem.imem_req = 1'b1;
         EXEC:    instr_valid   = 1'b1;
         HALTED:  halted        = 1'b1;
         default: ;
      endcase
   end

   assign imem.imem_addr = pc;
   assign opcode         = instr[IW-1:IW-6];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr <= '0;
      end else if (state == FETCH && imem.imem_ack) begin
         instr <= imem.imem_data;
      end
   end

   // Jump target is the low AW bits of the instruction word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc <= '0;
      end else if (state == EXEC) begin
         pc <= s_inc ? pc + 1'b1 : instr[AW-1:0];
      end
   end

   // Saturating: a stuck-at-max count is more useful than a wrapped one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retired <= '0;
      end else if (state == EXEC && retired != '1) begin
         retired <= retired + 1'b1;
      end
   end

endmodule
